// File: rtl/floor_request_latch_if.sv
// rtl/floor_request_latch_if.sv - call-button / floor / request signal bundle for floor_request_latch
interface floor_request_latch_if;
  logic [4:0] btn;
  logic [2:0] floor;
  logic [4:0] req;
  logic       door_open;
  logic       busy;

  // Producer side: button panel and controller floor feed, consumer of requests
  modport master (
    output btn,
    output floor,
    input  req,
    input  door_open,
    input  busy
  );

  // Latch side: takes buttons and floor, produces held requests and door state
  modport slave (
    input  btn,
    input  floor,
    output req,
    output door_open,
    output busy
  );
endinterface

// File: rtl/floor_request_latch.sv
// rtl/floor_request_latch.sv - call-button request latch with door-dwell FSM; optional BTN_SYNC_EN input synchronizer
module floor_request_latch #(
  parameter int DWELL_CYCLES = 8  // legal 2..255
) (
  input logic                  clk,
  input logic                  rst,
  floor_request_latch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(DWELL_CYCLES - 1);

  logic [4:0] btn_s;
  logic [4:0] btn_q;
  logic [4:0] press;
  logic [7:0] press_ext;
  logic [4:0] pending;
  logic [4:0] pending_nxt;
  logic [7:0] pending_ext;
  logic [4:0] clr_mask;
  logic       floor_hit;
  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [2:0] f_l;
  logic [2:0] f_l_nxt;
  logic       serve_clr;

`ifdef BTN_SYNC_EN
  logic [4:0] btn_m;
  logic [4:0] btn_mm;

  // Two-flop synchronizer for raw asynchronous button levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m  <= '0;
      btn_mm <= '0;
    end else begin
      btn_m  <= bus.btn;
      btn_mm <= btn_m;
    end
  end

  assign btn_s = btn_mm;
`else
  assign btn_s = bus.btn;
`endif

  // Button history for rising-edge detection; a held button registers once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn_s;
    end
  end

  assign press = btn_s & ~btn_q;

  // Zero-padded to 8 entries so floor codes 5..7 index a defined 0
  assign press_ext   = {3'b000, press};
  assign pending_ext = {3'b000, pending};
  assign floor_hit   = (bus.floor < 3'd5) && pending_ext[bus.floor];

  // Next-state and dwell counter control; door output is decoded from state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    f_l_nxt   = f_l;
    serve_clr = 1'b0;
    case (state)
      IDLE: begin
        if (floor_hit) begin
          f_l_nxt   = bus.floor;
          cnt_nxt   = CNT_LOAD;
          state_nxt = OPEN;
        end
      end
      OPEN: begin
        if (bus.floor != f_l) begin
          // Car left before the dwell ended; request stays pending
          state_nxt = IDLE;
        end else if (press_ext[f_l]) begin
          // Re-press at the served floor holds the door open again
          cnt_nxt = CNT_LOAD;
        end else if (cnt == 8'd0) begin
          state_nxt = CLOSE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      CLOSE: begin
        serve_clr = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, dwell counter and latched service floor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      f_l   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      f_l   <= f_l_nxt;
    end
  end

  // Pending update: serve clears first, a same-cycle press sets it back
  always_comb begin
    clr_mask    = serve_clr ? 5'(5'b00001 << f_l) : 5'b00000;
    pending_nxt = (pending & ~clr_mask) | press;
  end

  // Held request register, which is the request output itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign bus.req       = pending;
  assign bus.door_open = (state == OPEN);
  assign bus.busy      = |pending;

endmodule

// File: tb/tb_floor_request_latch.sv
// tb/tb_floor_request_latch.sv - self-checking bench for floor_request_latch with behavioural reference model
module tb_floor_request_latch;

  localparam int DWELL = 8;
`ifdef BTN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  floor_request_latch_if bus_if ();

  floor_request_latch #(.DWELL_CYCLES(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: requests as a bit set, door as "open cycles remaining"
  logic [4:0] m_pend;
  logic [4:0] m_bq;
  logic [4:0] m_d1;
  logic [4:0] m_d2;
  int         m_left;
  int         m_serve;
  bit         m_closing;

  task automatic model_reset();
    m_pend    = '0;
    m_bq      = '0;
    m_d1      = '0;
    m_d2      = '0;
    m_left    = 0;
    m_serve   = -1;
    m_closing = 1'b0;
  endtask

  task automatic model_step();
    logic [4:0] bs;
    logic [4:0] pr;
    logic [4:0] pn;
    if (SYNC_LAT != 0) begin
      bs   = m_d2;
      m_d2 = m_d1;
      m_d1 = bus_if.btn;
    end else begin
      bs = bus_if.btn;
    end
    pr   = bs & ~m_bq;
    m_bq = bs;
    pn   = m_pend;
    if (m_closing) begin
      if (m_serve >= 0) pn[m_serve] = 1'b0;
      m_closing = 1'b0;
      m_serve   = -1;
    end else if (m_left > 0) begin
      if (int'(bus_if.floor) != m_serve) begin
        m_left  = 0;
        m_serve = -1;
      end else if (pr[m_serve]) begin
        m_left = DWELL;
      end else if (m_left == 1) begin
        m_left    = 0;
        m_closing = 1'b1;
      end else begin
        m_left = m_left - 1;
      end
    end else if (bus_if.floor < 3'd5 && m_pend[bus_if.floor]) begin
      m_serve = int'(bus_if.floor);
      m_left  = DWELL;
    end
    m_pend = pn | pr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus_if.btn   = '0;
    bus_if.floor = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    n_total++;
    if ({bus_if.req, bus_if.door_open, bus_if.busy} !== 7'b0) begin
      $display("FAIL reset_outputs: got req=%b door=%b busy=%b want all 0", bus_if.req, bus_if.door_open, bus_if.busy);
    end else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if ({bus_if.req, bus_if.door_open, bus_if.busy} !== 7'b0) begin
      $display("FAIL reset_release: got req=%b door=%b busy=%b want all 0", bus_if.req, bus_if.door_open, bus_if.busy);
    end else n_pass++;
  endtask

  task automatic test_press_latency();
    bus_if.floor = 3'd0;
    bus_if.btn   = 5'b00100;
    for (int i = 0; i < SYNC_LAT + 1; i++) begin
      tick();
      bus_if.btn = '0;
      n_total++;
      if ({bus_if.req, bus_if.door_open, bus_if.busy} !== {m_pend, m_left > 0, |m_pend}) begin
        $display("FAIL press_latency_model step %0d: got %b/%b/%b want %b/%b/%b", i,
                 bus_if.req, bus_if.door_open, bus_if.busy, m_pend, m_left > 0, |m_pend);
      end else n_pass++;
    end
    n_total++;
    if (bus_if.req !== 5'b00100 || bus_if.door_open !== 1'b0) begin
      $display("FAIL press_latency: got req=%b door=%b want req=00100 door=0", bus_if.req, bus_if.door_open);
    end else n_pass++;
  endtask

  task automatic test_serve();
    int opens;
    opens = 0;
    bus_if.floor = 3'd2;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_if.door_open === 1'b1) opens++;
      n_total++;
      if ({bus_if.req, bus_if.door_open, bus_if.busy} !== {m_pend, m_left > 0, |m_pend}) begin
        $display("FAIL serve_model cycle %0d: got %b/%b/%b want %b/%b/%b", i,
                 bus_if.req, bus_if.door_open, bus_if.busy, m_pend, m_left > 0, |m_pend);
      end else n_pass++;
    end
    n_total++;
    if (opens !== DWELL) begin
      $display("FAIL serve_dwell: got %0d open cycles want %0d", opens, DWELL);
    end else n_pass++;
    n_total++;
    if (bus_if.req !== 5'b0 || bus_if.busy !== 1'b0) begin
      $display("FAIL serve_clear: got req=%b busy=%b want 00000/0", bus_if.req, bus_if.busy);
    end else n_pass++;
  endtask

  task automatic test_repress();
    int  opens;
    bit  fired;
    opens = 0;
    fired = 1'b0;
    bus_if.floor = 3'd0;
    bus_if.btn   = 5'b01000;
    tick();
    bus_if.btn = '0;
    repeat (SYNC_LAT) tick();
    bus_if.floor = 3'd3;
    for (int i = 0; i < 30; i++) begin
      tick();
      bus_if.btn = '0;
      if (bus_if.door_open === 1'b1) opens++;
      n_total++;
      if ({bus_if.req, bus_if.door_open, bus_if.busy} !== {m_pend, m_left > 0, |m_pend}) begin
        $display("FAIL repress_model cycle %0d: got %b/%b/%b want %b/%b/%b", i,
                 bus_if.req, bus_if.door_open, bus_if.busy, m_pend, m_left > 0, |m_pend);
      end else n_pass++;
      if (!fired && m_left == 3 + SYNC_LAT) begin
        bus_if.btn = 5'b01000;
        fired = 1'b1;
      end
    end
    n_total++;
    if (!fired || opens !== (DWELL - 2) + DWELL) begin
      $display("FAIL repress_dwell: got %0d open cycles (fired=%0d) want %0d", opens, fired, (DWELL - 2) + DWELL);
    end else n_pass++;
  endtask

  task automatic test_held_button();
    bus_if.floor = 3'd4;
    bus_if.btn   = 5'b00010;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_total++;
      if ({bus_if.req, bus_if.door_open, bus_if.busy} !== {m_pend, m_left > 0, |m_pend}) begin
        $display("FAIL held_model cycle %0d: got %b/%b/%b want %b/%b/%b", i,
                 bus_if.req, bus_if.door_open, bus_if.busy, m_pend, m_left > 0, |m_pend);
      end else n_pass++;
    end
    n_total++;
    if (bus_if.req !== 5'b00010) begin
      $display("FAIL held_set_once: got req=%b want 00010", bus_if.req);
    end else n_pass++;
    bus_if.floor = 3'd1;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_total++;
      if ({bus_if.req, bus_if.door_open, bus_if.busy} !== {m_pend, m_left > 0, |m_pend}) begin
        $display("FAIL held_serve_model cycle %0d: got %b/%b/%b want %b/%b/%b", i,
                 bus_if.req, bus_if.door_open, bus_if.busy, m_pend, m_left > 0, |m_pend);
      end else n_pass++;
    end
    n_total++;
    if (bus_if.req[1] !== 1'b0 || bus_if.door_open !== 1'b0) begin
      $display("FAIL held_no_reregister: got req=%b door=%b want req[1]=0 door=0", bus_if.req, bus_if.door_open);
    end else n_pass++;
    bus_if.btn = '0;
    tick();
  endtask

  task automatic test_press_during_close();
    bit fired;
    fired = 1'b0;
    bus_if.floor = 3'd0;
    bus_if.btn   = 5'b00001;
    tick();
    bus_if.btn = '0;
    for (int i = 0; i < 30 && !fired; i++) begin
      tick();
      if ((SYNC_LAT == 0 && m_closing) || (SYNC_LAT != 0 && m_left == 2)) fired = 1'b1;
    end
    n_total++;
    if (!fired) begin
      $display("FAIL close_press_timeout: close cycle not reached, got fired=0 want 1");
    end else n_pass++;
    bus_if.btn = 5'b00001;
    for (int i = 0; i < SYNC_LAT + 1; i++) begin
      tick();
      bus_if.btn = '0;
    end
    n_total++;
    if (bus_if.req[0] !== 1'b1 || bus_if.req !== m_pend) begin
      $display("FAIL close_press_set_wins: got req=%b want req[0]=1 (model %b)", bus_if.req, m_pend);
    end else n_pass++;
    tick();
    n_total++;
    if (bus_if.door_open !== 1'b1) begin
      $display("FAIL close_press_reopen: got door=%b want 1", bus_if.door_open);
    end else n_pass++;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_total++;
      if ({bus_if.req, bus_if.door_open, bus_if.busy} !== {m_pend, m_left > 0, |m_pend}) begin
        $display("FAIL close_press_model cycle %0d: got %b/%b/%b want %b/%b/%b", i,
                 bus_if.req, bus_if.door_open, bus_if.busy, m_pend, m_left > 0, |m_pend);
      end else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    bus_if.floor = 3'd2;
    bus_if.btn   = 5'b10011;
    tick();
    bus_if.btn = '0;
    repeat (SYNC_LAT) tick();
    bus_if.floor = 3'd0;
    repeat (3) tick();
    n_total++;
    if (bus_if.req !== 5'b10011 || bus_if.door_open !== 1'b1) begin
      $display("FAIL async_setup: got req=%b door=%b want 10011/1", bus_if.req, bus_if.door_open);
    end else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({bus_if.req, bus_if.door_open, bus_if.busy} !== 7'b0) begin
      $display("FAIL async_reset: got req=%b door=%b busy=%b want all 0", bus_if.req, bus_if.door_open, bus_if.busy);
    end else n_pass++;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    tick();
    n_total++;
    if ({bus_if.req, bus_if.door_open, bus_if.busy} !== 7'b0) begin
      $display("FAIL async_reset_hold: got req=%b door=%b busy=%b want all 0", bus_if.req, bus_if.door_open, bus_if.busy);
    end else n_pass++;
  endtask

  task automatic test_invalid_floor();
    bus_if.floor = 3'd6;
    bus_if.btn   = 5'b11111;
    tick();
    bus_if.btn = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_total++;
      if ({bus_if.req, bus_if.door_open, bus_if.busy} !== {m_pend, m_left > 0, |m_pend}) begin
        $display("FAIL invalid_floor_model cycle %0d: got %b/%b/%b want %b/%b/%b", i,
                 bus_if.req, bus_if.door_open, bus_if.busy, m_pend, m_left > 0, |m_pend);
      end else n_pass++;
    end
    n_total++;
    if (bus_if.req !== 5'b11111 || bus_if.door_open !== 1'b0) begin
      $display("FAIL invalid_floor: got req=%b door=%b want 11111/0", bus_if.req, bus_if.door_open);
    end else n_pass++;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        bus_if.floor = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        hold = $urandom_range(1, 20);
      end else begin
        hold--;
      end
      bus_if.btn = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      tick();
      n_total++;
      if ({bus_if.req, bus_if.door_open, bus_if.busy} !== {m_pend, m_left > 0, |m_pend}) begin
        $display("FAIL random_model cycle %0d: got %b/%b/%b want %b/%b/%b", i,
                 bus_if.req, bus_if.door_open, bus_if.busy, m_pend, m_left > 0, |m_pend);
      end else n_pass++;
    end
    bus_if.btn = '0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_press_latency();
    test_serve();
    test_repress();
    test_held_button();
    test_press_during_close();
    test_async_reset();
    test_invalid_floor();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
